// File: rtl/gen_event_collector.sv
// rtl/gen_event_collector.sv - timestamps per-lane event pulses and drains them as a valid/ready report stream
// Optional feature macro: GEN_EVENT_COLLECTOR_DONE_EN (adds done_o / seen_o completion tracking)
module gen_event_collector #(
  parameter int NUM_LANES = 5,
  parameter int TS_W      = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_LANES-1:0]                       ev_i,
  output logic                                       rpt_valid,
  input  logic                                       rpt_ready,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] rpt_lane,
  output logic [TS_W-1:0]                            rpt_time,
`ifdef GEN_EVENT_COLLECTOR_DONE_EN
  output logic                                       done_o,
  output logic [NUM_LANES-1:0]                       seen_o,
`endif
  output logic [NUM_LANES-1:0]                       ovf_o
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [TS_W-1:0]      ts_cnt;
  logic [NUM_LANES-1:0] pending;
  logic [TS_W-1:0]      ts_q [NUM_LANES];

  logic                 slot_free;
  logic                 found;
  logic                 load;
  logic [LANE_W-1:0]    sel;
  logic [TS_W-1:0]      sel_ts;
  logic [NUM_LANES-1:0] take;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end

  // Fixed priority: the lowest-index pending lane wins the free slot.
  always_comb begin
    slot_free = !rpt_valid || rpt_ready;
    found     = 1'b0;
    sel       = '0;
    sel_ts    = '0;
    take      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pending[i] && !found) begin
        found   = 1'b1;
        sel     = LANE_W'(i);
        sel_ts  = ts_q[i];
        take[i] = 1'b1;
      end
    end
    load = slot_free && found;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic            pend_r;
    logic            ovf_r;
    logic [TS_W-1:0] ts_r;
    logic            leaving;

    // A lane handing its event to the slot this edge can accept a new one.
    assign leaving = load && take[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_r <= 1'b0;
        ovf_r  <= 1'b0;
        ts_r   <= '0;
      end else if (ev_i[g]) begin
        if (!pend_r || leaving) begin
          pend_r <= 1'b1;
          ts_r   <= ts_cnt;
        end else begin
          ovf_r  <= 1'b1;
        end
      end else if (leaving) begin
        pend_r <= 1'b0;
      end
    end

    assign pending[g] = pend_r;
    assign ovf_o[g]   = ovf_r;
    assign ts_q[g]    = ts_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_valid <= 1'b0;
      rpt_lane  <= '0;
      rpt_time  <= '0;
    end else if (slot_free) begin
      if (found) begin
        rpt_valid <= 1'b1;
        rpt_lane  <= sel;
        rpt_time  <= sel_ts;
      end else begin
        rpt_valid <= 1'b0;
      end
    end
  end

`ifdef GEN_EVENT_COLLECTOR_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_o <= '0;
      done_o <= 1'b0;
    end else begin
      if (rpt_valid && rpt_ready) seen_o[rpt_lane] <= 1'b1;
      done_o <= &seen_o;
    end
  end
`endif

endmodule

// File: tb/tb_gen_event_collector.sv
// tb/tb_gen_event_collector.sv - vector table, directed sequences and random model check for gen_event_collector
module tb_gen_event_collector;

  logic        clk;
  logic        rst;
  logic [4:0]  ev;
  logic        ready;
  logic        valid;
  logic [2:0]  lane;
  logic [15:0] tstamp;
  logic [4:0]  ovf;

  logic        w_rst;
  logic [4:0]  w_ev;
  logic        w_ready;
  logic        w_valid;
  logic [2:0]  w_lane;
  logic [3:0]  w_time;
  logic [4:0]  w_ovf;

`ifdef GEN_EVENT_COLLECTOR_DONE_EN
  logic        done;
  logic [4:0]  seen;
  logic        w_done;
  logic [4:0]  w_seen;
`endif

  gen_event_collector #(.NUM_LANES(5), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .ev_i(ev), .rpt_valid(valid), .rpt_ready(ready),
    .rpt_lane(lane), .rpt_time(tstamp),
`ifdef GEN_EVENT_COLLECTOR_DONE_EN
    .done_o(done), .seen_o(seen),
`endif
    .ovf_o(ovf)
  );

  gen_event_collector #(.NUM_LANES(5), .TS_W(4)) dut_w (
    .clk(clk), .rst(w_rst), .ev_i(w_ev), .rpt_valid(w_valid), .rpt_ready(w_ready),
    .rpt_lane(w_lane), .rpt_time(w_time),
`ifdef GEN_EVENT_COLLECTOR_DONE_EN
    .done_o(w_done), .seen_o(w_seen),
`endif
    .ovf_o(w_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: one-deep mailbox per lane feeding a single report slot.
  bit          m_pend [5];
  int          m_ts   [5];
  int          m_cnt;
  bit          m_valid;
  int          m_lane;
  int          m_time;
  bit [4:0]    m_ovf;
  bit [4:0]    m_seen;
  bit          m_done;
  bit          chk_model = 0;

  task automatic model_step();
    int pick;
    if (rst) begin
      m_cnt = 0; m_valid = 0; m_lane = 0; m_time = 0; m_ovf = '0; m_seen = '0; m_done = 0;
      foreach (m_pend[i]) begin m_pend[i] = 0; m_ts[i] = 0; end
    end else begin
      m_done = (m_seen == 5'h1f);
      if (m_valid && ready) m_seen[m_lane] = 1'b1;
      if (!m_valid || ready) begin
        pick = -1;
        for (int i = 4; i >= 0; i--) if (m_pend[i]) pick = i;
        if (pick >= 0) begin
          m_valid = 1; m_lane = pick; m_time = m_ts[pick]; m_pend[pick] = 0;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (ev[i]) begin
          if (!m_pend[i]) begin m_pend[i] = 1; m_ts[i] = m_cnt; end
          else m_ovf[i] = 1'b1;
        end
      end
      m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (chk_model) begin
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_lane", 32'(lane), 32'(m_lane));
      chk("model_time", 32'(tstamp), 32'(m_time));
      chk("model_ovf", 32'(ovf), 32'(m_ovf));
`ifdef GEN_EVENT_COLLECTOR_DONE_EN
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_seen", 32'(seen), 32'(m_seen));
`endif
    end
  endtask

  typedef struct {
    logic        r;
    logic [4:0]  e;
    logic        y;
    logic        v;
    logic [2:0]  l;
    logic [15:0] t;
    logic [4:0]  o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [4:0] e, input logic y,
                     input logic v, input logic [2:0] l, input logic [15:0] t, input logic [4:0] o);
    vec_t x;
    x.r = r; x.e = e; x.y = y; x.v = v; x.l = l; x.t = t; x.o = o;
    tbl.push_back(x);
  endtask

  task automatic add_rst();
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
  endtask

  int hs_lane [$];
  int hs_time [$];
  int hs_idx  [$];

  initial begin
    rst = 1; ev = '0; ready = 0;
    w_rst = 1; w_ev = '0; w_ready = 0;

    // Simultaneous: all lanes at ts 7, drained one per cycle in lane order.
    add_rst();
    for (int k = 0; k < 7; k++) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 5'h1f, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 1, 3'(k), 7, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // Backpressure: lane 3 at ts 4 held stable, then lane 0 at ts 6.
    add_rst();
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 5'h08, 0, 0, 0, 0, 0);
    add(0, 0,     0, 1, 3, 4, 0);
    add(0, 5'h01, 0, 1, 3, 4, 0);
    add(0, 0,     0, 1, 3, 4, 0);
    add(0, 0,     1, 1, 0, 6, 0);
    add(0, 0,     1, 0, 0, 0, 0);
    // Overflow: lane 2 fires twice while the slot is stuck on lane 0.
    add_rst();
    add(0, 0,     0, 0, 0, 0, 0);
    add(0, 5'h01, 0, 0, 0, 0, 0);
    for (int k = 2; k < 5; k++) add(0, 0, 0, 1, 0, 1, 0);
    add(0, 5'h04, 0, 1, 0, 1, 0);
    for (int k = 6; k < 9; k++) add(0, 0, 0, 1, 0, 1, 0);
    add(0, 5'h04, 0, 1, 0, 1, 5'h04);
    add(0, 0,     1, 1, 2, 5, 5'h04);
    add(0, 0,     1, 0, 0, 0, 5'h04);
    add(0, 0,     1, 0, 0, 0, 5'h04);
    // Reset with a report in flight and lanes pending.
    add_rst();
    add(0, 5'h1f, 0, 0, 0, 0, 0);
    add(0, 0,     0, 1, 0, 0, 0);
    add(1, 5'h1f, 0, 0, 0, 0, 0);
    add(1, 0,     0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      rst = tbl[n].r; ev = tbl[n].e; ready = tbl[n].y;
      tick();
      chk($sformatf("vec%0d_valid", n), 32'(valid), 32'(tbl[n].v));
      chk($sformatf("vec%0d_ovf", n), 32'(ovf), 32'(tbl[n].o));
      if (tbl[n].v || tbl[n].r) begin
        chk($sformatf("vec%0d_lane", n), 32'(lane), 32'(tbl[n].l));
        chk($sformatf("vec%0d_time", n), 32'(tstamp), 32'(tbl[n].t));
      end
    end

    // Stagger: lane i fires at ts 10*i with the sink always ready.
    rst = 1; ev = '0; ready = 1;
    tick(); tick();
    rst = 0;
    chk_model = 1;
    for (int c = 0; c < 50; c++) begin
      ev = ((c % 10) == 0) ? 5'(1 << (c / 10)) : 5'h0;
      tick();
      if (valid) begin
        hs_lane.push_back(int'(lane));
        hs_time.push_back(int'(tstamp));
        hs_idx.push_back(c);
      end
    end
    ev = '0;
    tick();
    chk("stagger_count", 32'(hs_lane.size()), 5);
    for (int i = 0; i < hs_lane.size() && i < 5; i++) begin
      chk($sformatf("stagger%0d_lane", i), 32'(hs_lane[i]), 32'(i));
      chk($sformatf("stagger%0d_time", i), 32'(hs_time[i]), 32'(10 * i));
      chk($sformatf("stagger%0d_latency", i), 32'(hs_idx[i]), 32'(10 * i + 1));
    end
    chk("stagger_ovf", 32'(ovf), 0);
`ifdef GEN_EVENT_COLLECTOR_DONE_EN
    chk("stagger_done", 32'(done), 1);
    chk("stagger_seen", 32'(seen), 32'h1f);
`endif

    // Random traffic with occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 5; i++) ev[i] = ($urandom_range(0, 7) == 0);
      tick();
    end
    chk_model = 0;
    rst = 1; ev = '0;
    tick();

    // Narrow counter wrap: events at ts 15 and ts 1.
    w_rst = 1; tick(); tick();
    w_rst = 0; w_ready = 1;
    for (int k = 0; k < 20; k++) begin
      w_ev = (k == 15 || k == 17) ? 5'h01 : 5'h00;
      tick();
      if (k == 16) begin
        chk("wrap_first_valid", 32'(w_valid), 1);
        chk("wrap_first_time", 32'(w_time), 15);
      end
      if (k == 17) chk("wrap_gap_valid", 32'(w_valid), 0);
      if (k == 18) begin
        chk("wrap_second_valid", 32'(w_valid), 1);
        chk("wrap_second_time", 32'(w_time), 1);
      end
    end
    chk("wrap_ovf", 32'(w_ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
